// File: rtl/player_packet_decoder.sv
// ============================================================================
// player_packet_decoder
//
// Recovers framed player-action packets from a serial bit stream (MSB of each
// word first), validates the header and XOR checksum, and stores the action
// word of each accepted packet in a per-player register bank.
//
// Frame layout (all words WORD_W bits):
//   SYNC_WORD | header {player ID, LEN} | LEN payload words | checksum
//   checksum = header ^ payload[0] ^ ... ^ payload[LEN-1]
//   The first INFO_WORDS payload words form the action, first word in the MSBs.
//
// Optional feature macro: DECODER_TIMEOUT_EN
//   When defined, a packet is abandoned with err code 3 after TIMEOUT_CYC
//   consecutive cycles without a valid bit while in HEADER, DATA or CHECK.
//   When undefined, the decoder waits indefinitely mid-packet.
//
// Ports:
//   clk_in          system clock
//   rst_in          synchronous active-low reset
//   data_in         serial data bit
//   valid_in        data_in carries a bit this cycle
//   info_out        action word of the last accepted packet
//   player_out      player ID of the last accepted packet
//   info_valid_out  one-cycle pulse on packet acceptance
//   err_out         one-cycle pulse on packet rejection
//   err_code_out    rejection cause (1 header, 2 checksum, 3 timeout)
//   rd_player_in    player table read address
//   rd_info_out     combinational read of the player table
// ============================================================================
module player_packet_decoder #(
    parameter int              WORD_W      = 16,
    parameter logic [WORD_W-1:0] SYNC_WORD = 16'hA55A,
    parameter int              NUM_PLAYERS = 4,
    parameter int              INFO_WORDS  = 2,
    parameter int              MAX_LEN     = 8,
    parameter int              TIMEOUT_CYC = 1024
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   data_in,
    input  logic                                   valid_in,
    output logic [INFO_WORDS*WORD_W-1:0]           info_out,
    output logic [$clog2(NUM_PLAYERS)-1:0]         player_out,
    output logic                                   info_valid_out,
    output logic                                   err_out,
    output logic [1:0]                             err_code_out,
    input  logic [$clog2(NUM_PLAYERS)-1:0]         rd_player_in,
    output logic [INFO_WORDS*WORD_W-1:0]           rd_info_out
);

    localparam int INFO_W = INFO_WORDS * WORD_W;
    localparam int ID_W   = $clog2(NUM_PLAYERS);
    localparam int HALF   = WORD_W / 2;
    localparam int BC_W   = $clog2(WORD_W);

    localparam logic [HALF-1:0] NUM_PLAYERS_H = HALF'(NUM_PLAYERS);
    localparam logic [HALF-1:0] INFO_WORDS_H  = HALF'(INFO_WORDS);
    localparam logic [HALF-1:0] MAX_LEN_H     = HALF'(MAX_LEN);
    localparam logic [BC_W-1:0] LAST_BIT      = BC_W'(WORD_W - 1);

    localparam logic [1:0] ERR_HEADER   = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;

    typedef enum logic [1:0] {
        HUNT,
        HEADER,
        DATA,
        CHECK
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   window;
    logic [BC_W-1:0]     bit_cnt;
    logic [HALF-1:0]     word_cnt;
    logic [HALF-1:0]     len_q;
    logic [ID_W-1:0]     id_q;
    logic [WORD_W-1:0]   acc;
    logic [INFO_W-1:0]   staging;
    logic [INFO_W-1:0]   player_table [NUM_PLAYERS];

`ifdef DECODER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
    logic [TO_W-1:0]     idle_cnt;
`endif

    // Window contents after the bit offered this cycle is shifted in; every
    // word-level decision is made on this value so it takes effect on the
    // same edge that consumes the final bit.
    logic [WORD_W-1:0]   next_window;
    logic [HALF-1:0]     hdr_id;
    logic [HALF-1:0]     hdr_len;
    logic                hdr_bad;
    logic                word_done;

    always_comb begin
        next_window = {window[WORD_W-2:0], data_in};
        hdr_id      = next_window[WORD_W-1:HALF];
        hdr_len     = next_window[HALF-1:0];
        hdr_bad     = (hdr_id >= NUM_PLAYERS_H) ||
                      (hdr_len < INFO_WORDS_H) ||
                      (hdr_len > MAX_LEN_H);
        word_done   = (bit_cnt == LAST_BIT);
    end

    // Out-of-range addresses (non power-of-two tables) read as zero.
    always_comb begin
        rd_info_out = '0;
        if ({1'b0, rd_player_in} < (ID_W + 1)'(NUM_PLAYERS)) begin
            rd_info_out = player_table[rd_player_in];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state          <= HUNT;
            window         <= '0;
            bit_cnt        <= '0;
            word_cnt       <= '0;
            len_q          <= '0;
            id_q           <= '0;
            acc            <= '0;
            staging        <= '0;
            info_out       <= '0;
            player_out     <= '0;
            info_valid_out <= 1'b0;
            err_out        <= 1'b0;
            err_code_out   <= 2'd0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                player_table[i] <= '0;
            end
`ifdef DECODER_TIMEOUT_EN
            idle_cnt       <= '0;
`endif
        end else begin
            info_valid_out <= 1'b0;
            err_out        <= 1'b0;

`ifdef DECODER_TIMEOUT_EN
            // Idle counter only runs while a packet is open; any valid bit
            // restarts it.
            if (state != HUNT) begin
                if (valid_in) begin
                    idle_cnt <= '0;
                end else if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    err_out      <= 1'b1;
                    err_code_out <= ERR_TIMEOUT;
                    state        <= HUNT;
                    window       <= '0;
                    bit_cnt      <= '0;
                    idle_cnt     <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
`endif

            if (valid_in) begin
                window <= next_window;
                case (state)
                    HUNT: begin
                        // Sliding compare on every bit; no word alignment yet.
                        if (next_window == SYNC_WORD) begin
                            state   <= HEADER;
                            window  <= '0;
                            bit_cnt <= '0;
                        end
                    end

                    HEADER: begin
                        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                        if (word_done) begin
                            acc      <= next_window;
                            id_q     <= hdr_id[ID_W-1:0];
                            len_q    <= hdr_len;
                            word_cnt <= '0;
                            staging  <= '0;
                            if (hdr_bad) begin
                                err_out      <= 1'b1;
                                err_code_out <= ERR_HEADER;
                                state        <= HUNT;
                                window       <= '0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end

                    DATA: begin
                        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                        if (word_done) begin
                            acc      <= acc ^ next_window;
                            word_cnt <= word_cnt + 1'b1;
                            // Shifting left keeps the first captured word in
                            // the most significant position.
                            if (word_cnt < INFO_WORDS_H) begin
                                staging <= (staging << WORD_W) | INFO_W'(next_window);
                            end
                            if (word_cnt + 1'b1 == len_q) begin
                                state <= CHECK;
                            end
                        end
                    end

                    CHECK: begin
                        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                        if (word_done) begin
                            if (next_window == acc) begin
                                player_table[id_q] <= staging;
                                info_out           <= staging;
                                player_out         <= id_q;
                                info_valid_out     <= 1'b1;
                            end else begin
                                err_out      <= 1'b1;
                                err_code_out <= ERR_CHECKSUM;
                            end
                            // Fresh window so packet tail bits cannot
                            // combine with later bits into a false sync.
                            state  <= HUNT;
                            window <= '0;
                        end
                    end

                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_packet_decoder.sv
// ============================================================================
// tb_player_packet_decoder
//
// Scoreboard bench for player_packet_decoder. Each frame sent pushes its
// expected outcome (accept with info/player, or error with code) into a
// queue; an independent monitor pops and compares on every info_valid_out or
// err_out pulse. Table contents and held outputs are compared against a
// small reference table kept by the bench.
//
// Ports of the DUT are all connected by name; TIMEOUT_CYC is set to 16 so
// the timeout scenario is short when DECODER_TIMEOUT_EN is defined.
// ============================================================================
module tb_player_packet_decoder;

    logic        clk_in;
    logic        rst_in;
    logic        data_in;
    logic        valid_in;
    logic [31:0] info_out;
    logic [1:0]  player_out;
    logic        info_valid_out;
    logic        err_out;
    logic [1:0]  err_code_out;
    logic [1:0]  rd_player_in;
    logic [31:0] rd_info_out;

    typedef struct {
        bit          is_err;
        logic [31:0] info;
        logic [1:0]  player;
        logic [1:0]  code;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_table [4];
    logic [31:0] exp_info;
    logic [1:0]  exp_player;
    int          checks;
    int          errors;

    player_packet_decoder #(
        .WORD_W      (16),
        .SYNC_WORD   (16'hA55A),
        .NUM_PLAYERS (4),
        .INFO_WORDS  (2),
        .MAX_LEN     (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .info_out       (info_out),
        .player_out     (player_out),
        .info_valid_out (info_valid_out),
        .err_out        (err_out),
        .err_code_out   (err_code_out),
        .rd_player_in   (rd_player_in),
        .rd_info_out    (rd_info_out)
    );

    // 10 ns clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Hard time limit so a stuck design still ends the run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: compare every output pulse with the head of the scoreboard
    always @(negedge clk_in) begin
        exp_t e;
        if (info_valid_out && err_out) begin
            checks++;
            errors++;
            $display("[TB] FAIL pulse_overlap: got info_valid=1 err=1 expected at most one");
        end else if (info_valid_out || err_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got info_valid=%0b err=%0b code=%0d expected none",
                         info_valid_out, err_out, err_code_out);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_kind", {31'b0, err_out}, {31'b0, e.is_err});
                if (e.is_err) begin
                    checkOutput("err_code", {30'b0, err_code_out}, {30'b0, e.code});
                end else begin
                    checkOutput("info_out", info_out, e.info);
                    checkOutput("player_out", {30'b0, player_out}, {30'b0, e.player});
                end
            end
        end
    end

    task automatic expectAccept(input logic [1:0] player, input logic [31:0] info);
        exp_t e;
        e.is_err = 1'b0;
        e.info   = info;
        e.player = player;
        e.code   = 2'd0;
        exp_q.push_back(e);
        exp_table[player] = info;
        exp_info          = info;
        exp_player        = player;
    endtask

    task automatic expectError(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1;
        e.info   = '0;
        e.player = '0;
        e.code   = code;
        exp_q.push_back(e);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Send one bit; optional random idle gap of 0..gap_max cycles before it
    task automatic sendBit(input logic b, input int gap_max);
        if (gap_max > 0) idleCycles($urandom_range(0, gap_max));
        data_in  = b;
        valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        data_in  = 1'b0;
    endtask

    // Send one 16-bit word MSB first
    task automatic applyStimulus(input logic [15:0] word, input int gap_max);
        for (int i = 15; i >= 0; i--) begin
            sendBit(word[i], gap_max);
        end
    endtask

    task automatic checkTable(input string tag);
        for (int p = 0; p < 4; p++) begin
            rd_player_in = 2'(p);
            #1;
            checkOutput($sformatf("%s_rd_info[%0d]", tag, p), rd_info_out, exp_table[p]);
        end
        checkOutput({tag, "_info_out"}, info_out, exp_info);
        checkOutput({tag, "_player_out"}, {30'b0, player_out}, {30'b0, exp_player});
        @(posedge clk_in);
        #1;
    endtask

    task automatic drainQueue(input string tag);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) idleCycles(1);
        checkOutput({tag, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] junk;
        checks     = 0;
        errors     = 0;
        rst_in     = 1'b0;
        data_in    = 1'b0;
        valid_in   = 1'b0;
        rd_player_in = '0;
        exp_info   = '0;
        exp_player = '0;
        for (int i = 0; i < 4; i++) exp_table[i] = '0;

        idleCycles(3);
        rst_in = 1'b1;

        // Reset state
        checkOutput("reset_info_valid", {31'b0, info_valid_out}, 32'd0);
        checkOutput("reset_err", {31'b0, err_out}, 32'd0);
        checkOutput("reset_err_code", {30'b0, err_code_out}, 32'd0);
        checkTable("reset");

        // Accept: player 1, DEADBEEF
        $display("[TB] accept frame");
        expectAccept(2'd1, 32'hDEADBEEF);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0102, 0);
        applyStimulus(16'hDEAD, 0);
        applyStimulus(16'hBEEF, 0);
        applyStimulus(16'h6140, 0);
        drainQueue("accept");
        checkTable("accept");

        // Bad checksum: table and held outputs untouched
        $display("[TB] bad checksum frame");
        expectError(2'd2);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0102, 0);
        applyStimulus(16'h1111, 0);
        applyStimulus(16'h2222, 0);
        applyStimulus(16'h6141, 0);
        drainQueue("badcs");
        checkTable("badcs");

        // Good frame after error, LEN above INFO_WORDS (extra word checked only)
        $display("[TB] player 2 frame with extra payload word");
        expectAccept(2'd2, 32'h12345678);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0203, 0);
        applyStimulus(16'h1234, 0);
        applyStimulus(16'h5678, 0);
        applyStimulus(16'h9ABC, 0);
        applyStimulus(16'hDCF3, 0);
        drainQueue("len3");
        checkTable("len3");

        // Bad header: ID 5 out of range, payload bits are then hunted
        $display("[TB] bad header id");
        expectError(2'd1);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0502, 0);
        applyStimulus(16'hDEAD, 0);
        applyStimulus(16'hBEEF, 0);
        applyStimulus(16'h6140, 0);
        drainQueue("badid");
        checkTable("badid");

        // LEN below INFO_WORDS and above MAX_LEN
        $display("[TB] bad header lengths");
        expectError(2'd1);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0001, 0);
        expectError(2'd1);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0309, 0);
        drainQueue("badlen");

        // Boundaries: highest ID with LEN = MAX_LEN, lowest ID with LEN = INFO_WORDS
        $display("[TB] boundary frames");
        expectAccept(2'd3, 32'h00010002);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0308, 0);
        for (int w = 1; w <= 8; w++) applyStimulus(16'(w), 0);
        applyStimulus(16'h0300, 0);
        expectAccept(2'd0, 32'hAAAA5555);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0002, 0);
        applyStimulus(16'hAAAA, 0);
        applyStimulus(16'h5555, 0);
        applyStimulus(16'hFFFD, 0);
        drainQueue("bounds");
        checkTable("bounds");

        // Stall and hunt: leading junk and random gaps
        $display("[TB] junk prefix with random stalls");
        junk = 8'b1011_0101;
        expectAccept(2'd1, 32'hDEADBEEF);
        for (int i = 7; i >= 0; i--) sendBit(junk[i], 7);
        applyStimulus(16'hA55A, 7);
        applyStimulus(16'h0102, 7);
        applyStimulus(16'hDEAD, 7);
        applyStimulus(16'hBEEF, 7);
        applyStimulus(16'h6140, 7);
        drainQueue("stall");
        checkTable("stall");

        // Long mid-DATA pause
`ifdef DECODER_TIMEOUT_EN
        $display("[TB] timeout mid-DATA");
        expectError(2'd3);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0302, 0);
        applyStimulus(16'hCAFE, 0);
        idleCycles(20);
        drainQueue("timeout");
        checkTable("timeout");
`else
        $display("[TB] long pause mid-DATA without timeout");
        expectAccept(2'd3, 32'hCAFEF00D);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0302, 0);
        applyStimulus(16'hCAFE, 0);
        idleCycles(40);
        applyStimulus(16'hF00D, 0);
        applyStimulus(16'h39F1, 0);
        drainQueue("pause");
        checkTable("pause");
`endif

        // Reset mid-DATA clears everything
        $display("[TB] reset mid-packet");
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0203, 0);
        applyStimulus(16'h1234, 0);
        for (int i = 0; i < 8; i++) sendBit(1'b1, 0);
        rst_in = 1'b0;
        idleCycles(2);
        rst_in = 1'b1;
        for (int i = 0; i < 4; i++) exp_table[i] = '0;
        exp_info   = '0;
        exp_player = '0;
        checkOutput("rst_info_valid", {31'b0, info_valid_out}, 32'd0);
        checkOutput("rst_err", {31'b0, err_out}, 32'd0);
        checkOutput("rst_err_code", {30'b0, err_code_out}, 32'd0);
        checkTable("rst");

        // Decoder hunts from the first bit after reset
        $display("[TB] accept after reset");
        expectAccept(2'd1, 32'hDEADBEEF);
        applyStimulus(16'hA55A, 0);
        applyStimulus(16'h0102, 0);
        applyStimulus(16'hDEAD, 0);
        applyStimulus(16'hBEEF, 0);
        applyStimulus(16'h6140, 0);
        drainQueue("post_rst");
        checkTable("post_rst");

        idleCycles(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_packet_decoder.md
# player_packet_decoder

Parametrised successor to the single-channel bit-stream decoder. It recovers framed player-action packets from the serial UDP payload bit stream and checks each packet's header and checksum. Accepted actions go into a per-player register bank. It sits between the Ethernet RX deserialiser and game logic, which reads player actions either from the update strobe or from the table read port.

## Interface
Parameters:
- WORD_W, 16: framing word width in bits; sync, header, payload and checksum are all WORD_W.
- SYNC_WORD, 16'hA55A: frame start pattern.
- NUM_PLAYERS, 4: player table depth; legal IDs are 0..NUM_PLAYERS-1.
- INFO_WORDS, 2: payload words captured as the action; INFO_W = INFO_WORDS*WORD_W (32 by default).
- MAX_LEN, 8: maximum payload length in words.
- TIMEOUT_CYC, 1024: idle-cycle limit used only when DECODER_TIMEOUT_EN is defined.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous, active-low reset (0 = reset).
- data_in, input, 1: serial bit, MSB of each word first.
- valid_in, input, 1: data_in is a valid bit on this cycle.
- info_out, output, INFO_W: action word of the last accepted packet.
- player_out, output, $clog2(NUM_PLAYERS): player ID of the last accepted packet.
- info_valid_out, output, 1: one-cycle pulse when a packet is accepted.
- err_out, output, 1: one-cycle pulse when a packet is rejected.
- err_code_out, output, 2: rejection cause, valid with err_out. 1 = bad header, 2 = checksum, 3 = timeout.
- rd_player_in, input, $clog2(NUM_PLAYERS): table read address.
- rd_info_out, output, INFO_W: combinational read of table[rd_player_in].

## Operation
- Bits are consumed only on cycles with valid_in = 1. Cycles with valid_in = 0 change no datapath state.
- Each consumed bit shifts into a WORD_W window: window <= {window[WORD_W-2:0], data_in}. A bit counter counts to WORD_W, wraps to 0, and marks word completion.
- **HUNT**: sliding compare, with no bit counter. When the window equals SYNC_WORD after a shift, go to HEADER with the window cleared and the bit counter at 0.
- **HEADER**: collect one word.
  - [15:8] = player ID, [7:0] = LEN (for WORD_W = 16).
  - Checksum accumulator = header word.
  - If ID >= NUM_PLAYERS, or LEN < INFO_WORDS, or LEN > MAX_LEN: pulse err_out with code 1 and return to HUNT. Otherwise go to DATA.
- **DATA**: collect LEN words and XOR each one into the accumulator.
  - The first INFO_WORDS words are concatenated into a staging register, first word most significant.
  - Remaining words are checked only.
  - After word LEN, go to CHECK.
- **CHECK**: collect one word.
  - If it equals the accumulator, write staging into table[ID], drive info_out and player_out, and pulse info_valid_out.
  - Otherwise pulse err_out with code 2.
  - Either way, return to HUNT.
- After any packet end, HUNT restarts with a cleared window. Bits from the finished packet never form a sync match.
- A rejected packet leaves the table, info_out and player_out unchanged.

## Timing
- Reset values:
  - State = HUNT; window, counters and accumulator = 0.
  - All table entries = 0; info_out = 0; player_out = 0.
  - info_valid_out = 0; err_out = 0; err_code_out = 0.
- Registered outputs update on the clock edge that consumes the last checksum bit, so they are visible the following cycle.
- Header errors follow the same rule: they are reported from the edge that consumes the last header bit.
- info_valid_out and err_out are never high on the same cycle. Each is high for exactly one cycle per packet.
- rd_info_out has zero latency and reflects a table write from the following cycle onward.
- Gaps in valid_in of any length are legal and do not alter the result, except through the timeout.
- Reset mid-packet discards the packet and clears the table. The first valid bit after reset is a HUNT bit.

## Configuration
- DECODER_TIMEOUT_EN defined:
  - In HEADER, DATA or CHECK, a counter counts consecutive valid_in = 0 cycles and clears on each valid bit.
  - Reaching TIMEOUT_CYC pulses err_out with code 3 and returns to HUNT.
- Undefined: no timeout counter. The decoder waits indefinitely mid-packet, and code 3 is never produced.

## Test plan
- **Accept:** after reset, send A55A, 0x0102, DEAD, BEEF, 6140 continuously -> info_valid_out pulses once, info_out = 32'hDEADBEEF, player_out = 1, rd_info_out at address 1 = DEADBEEF, other entries = 0.
- **Bad checksum:** same frame with checksum 6141 -> err_out pulses once with code 2; table unchanged; a following good frame is accepted.
- **Bad header:** header 0x0502 with NUM_PLAYERS = 4 -> err code 1 on the last header bit; payload bits are hunted and produce no match.
- **Stall and hunt:** leading junk bits 1011_0101 before the frame, plus random valid_in gaps of up to 7 cycles -> same result as the accept test.
- **Timeout:** with DECODER_TIMEOUT_EN and TIMEOUT_CYC = 16, stop valid_in mid-DATA for 16 cycles -> err code 3.
- **Reset mid-packet:** assert rst_in = 0 mid-DATA -> all outputs and table entries are 0.
